wb_host_arbiter: RTL
====================

// Module: wb_host_arbiter
// PURPOSE
// - Two-master, one-slave Wishbone-classic arbiter in front of the bASIC core's shared bus slave.
// - Master 0 is the Caravel management Wishbone; master 1 is the on-chip UART debug master.
// - Round-robin grant, one transfer per grant, and a bus timeout that returns an error to the owner.
// - Sits inside top_level_bASIC, between the wrapper Wishbone pins / debug master and the internal bus.
// PARAMETERS
// - ADDR_W   32   address width, per master and slave
// - DATA_W   32   data width; select width is DATA_W/8
// - TIMEOUT  255  XFER cycles without s_ack_i before an error is returned (>=1); counter width $clog2(TIMEOUT+1)
// PORTS
// - wb_clk_i   in   1           single clock, all state on rising edge
// - wb_rst_i   in   1           asynchronous, active-high reset
// - m_cyc_i    in   2           per-master cycle; bit i = master i
// - m_stb_i    in   2           per-master strobe
// - m_we_i     in   2           per-master write enable
// - m_sel_i    in   2*DATA_W/8  byte selects; master i at [i*4+:4]
// - m_adr_i    in   2*ADDR_W    addresses; master i at [i*ADDR_W+:ADDR_W]
// - m_dat_i    in   2*DATA_W    write data, same packing
// - m_dat_o    out  DATA_W      read data, shared by both masters
// - m_ack_o    out  2           per-master acknowledge
// - m_err_o    out  2           per-master timeout error, one-cycle pulse
// - s_cyc_o    out  1           slave cycle
// - s_stb_o    out  1           slave strobe
// - s_we_o     out  1           slave write enable
// - s_sel_o    out  DATA_W/8    slave byte selects
// - s_adr_o    out  ADDR_W      slave address
// - s_dat_o    out  DATA_W      slave write data
// - s_dat_i    in   DATA_W      slave read data
// - s_ack_i    in   1           slave acknowledge
// - grant_o    out  2           one-hot current owner; 00 when idle
// BEHAVIOUR
// - Reset: state=IDLE, owner=0, last=1 (master 0 wins first), cnt=0.
//   All outputs are 0 while wb_rst_i is high and on release.
// - Request i = m_cyc_i[i] & m_stb_i[i].
// - FSM states: IDLE, XFER, ERR.
// - IDLE: with any request pending, owner <= requester (if both, the one != last); go to XFER; cnt <= 0.
//   s_* outputs are low in IDLE.
// - Latency: request seen at cycle N -> grant_o and s_cyc_o/s_stb_o high at N+1.
// - XFER: s_cyc/s_stb/s_we/s_sel/s_adr/s_dat are a combinational mux of the owner's live inputs.
//   grant_o is one-hot for the owner.
// - XFER + s_ack_i: m_ack_o[owner]=1 and m_dat_o=s_dat_i in the same cycle.
//   Next state IDLE; last <= owner.
// - XFER with no ack: cnt increments.
//   If no ack by the TIMEOUT-th XFER cycle, next state is ERR.
// - ERR (exactly 1 cycle): s_cyc_o=s_stb_o=0 and m_err_o[owner]=1; last <= owner; next state IDLE.
// - Abort: owner drops m_cyc_i in XFER -> s_cyc_o/s_stb_o low that cycle, no ack or err, IDLE next cycle.
//   An s_ack_i arriving in IDLE or ERR is ignored.
// - Ack and timeout in the same cycle: the ack wins and no error is raised.
// - Fixed one IDLE cycle between grants.
//   Two continuously requesting masters therefore alternate strictly, and neither can starve.
// - The non-owner never sees m_ack_o or m_err_o.
//   m_dat_o = 0 unless an ack is being forwarded.
// - Async reset mid-XFER: the slave cycle drops immediately and the transfer is not replayed.
// TESTING
// - Reset, then m0 writes adr 0x3000_0004 / dat 0xDEADBEEF / sel 0xF; slave acks on its 2nd XFER cycle
//   -> s_stb_o at N+1, s_dat_o=0xDEADBEEF, m_ack_o=01 in the ack cycle, grant_o=00 next cycle.
// - m1 reads; slave returns s_dat_i=0x1234_5678 with ack
//   -> m_dat_o=0x1234_5678, m_ack_o=10, m_ack_o[0] stays 0 throughout.
// - m0 and m1 both request continuously, slave acks in 1 cycle
//   -> grant_o sequence 01,00,10,00,01,... over 8 transfers.
// - TIMEOUT=8, slave never acks
//   -> 8 XFER cycles, then 1 cycle of m_err_o[owner]=1 with s_cyc_o=0, then the other master is served.
// - m0 drops cyc on XFER cycle 3 and the slave acks on cycle 4
//   -> no m_ack_o, FSM is in IDLE, the late ack is ignored, grant_o=00.
// - wb_rst_i pulsed mid-XFER
//   -> s_cyc_o, grant_o, m_ack_o and m_err_o are 0 asynchronously; the first grant after release goes to m0.

Source files
------------

// File: rtl/wb_host_arbiter.sv
// Two-master, one-slave Wishbone-classic arbiter for the bASIC shared bus slave.
// Master 0 is the Caravel management bus, master 1 the UART debug master.
// Round-robin grant, one transfer per grant, with a bus timeout that returns an error.
//
// Ports:
//   wb_clk_i, wb_rst_i      clock, asynchronous active-high reset
//   m_cyc_i/m_stb_i/m_we_i  per-master control, bit i = master i
//   m_sel_i/m_adr_i/m_dat_i per-master payload, master i in slice i
//   m_dat_o                 shared read data (zero unless an ack is forwarded)
//   m_ack_o/m_err_o         per-master acknowledge / timeout error
//   s_*                     slave-side Wishbone
//   grant_o                 one-hot current owner, 00 when idle
module wb_host_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic [1:0]              m_cyc_i,
    input  logic [1:0]              m_stb_i,
    input  logic [1:0]              m_we_i,
    input  logic [2*DATA_W/8-1:0]   m_sel_i,
    input  logic [2*ADDR_W-1:0]     m_adr_i,
    input  logic [2*DATA_W-1:0]     m_dat_i,
    output logic [DATA_W-1:0]       m_dat_o,
    output logic [1:0]              m_ack_o,
    output logic [1:0]              m_err_o,
    output logic                    s_cyc_o,
    output logic                    s_stb_o,
    output logic                    s_we_o,
    output logic [DATA_W/8-1:0]     s_sel_o,
    output logic [ADDR_W-1:0]       s_adr_o,
    output logic [DATA_W-1:0]       s_dat_o,
    input  logic [DATA_W-1:0]       s_dat_i,
    input  logic                    s_ack_i,
    output logic [1:0]              grant_o
);

    localparam int unsigned SEL_W = DATA_W / 8;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic               owner, owner_nxt;
    logic               last, last_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;

    logic [1:0]         req;
    logic               own_cyc, own_stb, own_we;
    logic [SEL_W-1:0]   own_sel;
    logic [ADDR_W-1:0]  own_adr;
    logic [DATA_W-1:0]  own_dat;

    assign req = m_cyc_i & m_stb_i;

    // Owner's live bus signals
    assign own_cyc = owner ? m_cyc_i[1] : m_cyc_i[0];
    assign own_stb = owner ? m_stb_i[1] : m_stb_i[0];
    assign own_we  = owner ? m_we_i[1]  : m_we_i[0];
    assign own_sel = owner ? m_sel_i[SEL_W +: SEL_W]   : m_sel_i[0 +: SEL_W];
    assign own_adr = owner ? m_adr_i[ADDR_W +: ADDR_W] : m_adr_i[0 +: ADDR_W];
    assign own_dat = owner ? m_dat_i[DATA_W +: DATA_W] : m_dat_i[0 +: DATA_W];

    // State register
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
            owner <= 1'b0;
            last  <= 1'b1;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            last  <= last_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state and bus outputs
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        last_nxt  = last;
        cnt_nxt   = cnt;
        m_dat_o   = '0;
        m_ack_o   = 2'b00;
        m_err_o   = 2'b00;
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        s_we_o    = 1'b0;
        s_sel_o   = '0;
        s_adr_o   = '0;
        s_dat_o   = '0;
        grant_o   = 2'b00;

        case (state)
            IDLE: begin
                if (|req) begin
                    // On contention the master that did not go last wins
                    owner_nxt = (req == 2'b11) ? ~last : req[1];
                    state_nxt = XFER;
                    cnt_nxt   = '0;
                end
            end
            XFER: begin
                grant_o = owner ? 2'b10 : 2'b01;
                s_we_o  = own_we;
                s_sel_o = own_sel;
                s_adr_o = own_adr;
                s_dat_o = own_dat;
                if (!own_cyc) begin
                    // Owner aborted: drop the slave cycle, no ack or error
                    state_nxt = IDLE;
                end else begin
                    s_cyc_o = 1'b1;
                    s_stb_o = own_stb;
                    if (s_ack_i) begin
                        // Ack takes priority over a coincident timeout
                        m_ack_o   = owner ? 2'b10 : 2'b01;
                        m_dat_o   = s_dat_i;
                        last_nxt  = owner;
                        state_nxt = IDLE;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        state_nxt = ERR;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            ERR: begin
                m_err_o   = owner ? 2'b10 : 2'b01;
                last_nxt  = owner;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
